// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the RV32 core writeback stage
package core_pkg;

  // Result select driven by decode; MEM routes the extracted load data.
  typedef enum logic [2:0] {
    REG_WSEL_ALU = 3'd0,
    REG_WSEL_IMM = 3'd1,
    REG_WSEL_PC  = 3'd2,
    REG_WSEL_PC4 = 3'd3,
    REG_WSEL_CSR = 3'd4,
    REG_WSEL_MEM = 3'd5
  } reg_wsel_t;

  // Load access types, encoded as the instruction funct3 field.
  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101
  } mem_type_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/core_load_extract.sv
// rtl/core_load_extract.sv - aligns and extends load data from a word-aligned bus read
module core_load_extract
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  mem_type,
  output logic [31:0] data
);

  logic [15:0] lo;

  always_comb begin
    // Only the low halfword of the shifted word feeds byte/halfword loads.
    lo = 16'(rdata >> {offset, 3'b000});
    case (mem_type)
      MEM_LB:  data = {{24{lo[7]}}, lo[7:0]};
      MEM_LH:  data = {{16{lo[15]}}, lo};
      MEM_LBU: data = {24'd0, lo[7:0]};
      MEM_LHU: data = {16'd0, lo};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/core_writeback.sv
// rtl/core_writeback.sv - W stage: load completion, result select, regfile write, bypass, instret
module core_writeback
  import core_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_pc,
  input  logic [31:0] w_pc4,
  input  logic [31:0] w_imm,
  input  logic [31:0] w_alu_out,
  input  logic [31:0] w_alu_sum,
  input  logic [31:0] w_csr_value,
  input  logic [4:0]  w_rd,
  input  logic        w_reg_wen,
  input  logic [2:0]  w_reg_wsel,
  input  logic [2:0]  w_mem_type,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data,
  input  logic        instret_inh,
  output logic [63:0] instret,
  output logic        load_fault
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t   state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [63:0] instret_q, instret_d;
  logic        byp_valid_q, byp_valid_d;
  logic [4:0]  byp_rd_q, byp_rd_d;
  logic [31:0] byp_data_q, byp_data_d;

  logic        is_load;
  logic        retire;
  logic        fault;
  logic [31:0] load_data;
  logic [31:0] result;

  // Address bits above the byte offset are not needed once the bus returns the word.
  logic unused_alu_sum;
  assign unused_alu_sum = ^w_alu_sum[31:2];

  core_load_extract u_load_extract (
    .rdata    (mem_rdata),
    .offset   (w_alu_sum[1:0]),
    .mem_type (w_mem_type),
    .data     (load_data)
  );

  always_comb begin
    is_load    = w_valid && (w_reg_wsel == REG_WSEL_MEM);
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    retire     = 1'b0;
    fault      = 1'b0;
    w_ready    = 1'b1;
    case (state_q)
      WB_IDLE: begin
        if (w_valid) begin
          if (!is_load || mem_rvalid) begin
            retire = 1'b1;
          end else begin
            w_ready    = 1'b0;
            state_d    = WB_WAIT;
            wait_cnt_d = CW'(1);
          end
        end
      end
      WB_WAIT: begin
        if (mem_rvalid) begin
          retire     = 1'b1;
          state_d    = WB_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CW'(LOAD_TIMEOUT)) begin
          // Abandon the load: the instruction still retires so the pipeline moves on.
          retire     = 1'b1;
          fault      = 1'b1;
          state_d    = WB_IDLE;
          wait_cnt_d = '0;
        end else begin
          w_ready    = 1'b0;
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = WB_IDLE;
        wait_cnt_d = '0;
      end
    endcase
    if (rst) begin
      retire = 1'b0;
      fault  = 1'b0;
    end
  end

  always_comb begin
    case (w_reg_wsel)
      REG_WSEL_ALU: result = w_alu_out;
      REG_WSEL_IMM: result = w_imm;
      REG_WSEL_PC:  result = w_pc;
      REG_WSEL_PC4: result = w_pc4;
      REG_WSEL_CSR: result = w_csr_value;
      REG_WSEL_MEM: result = load_data;
      default:      result = '0;
    endcase
  end

  always_comb begin
    rf_wen      = retire && w_reg_wen && (w_rd != 5'd0) && !fault;
    rf_waddr    = w_rd;
    rf_wdata    = result;
    load_fault  = fault;
    byp_valid_d = rf_wen;
    byp_rd_d    = rf_waddr;
    byp_data_d  = rf_wdata;
    instret_d   = instret_q;
    if (retire && !instret_inh) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      wait_cnt_q  <= '0;
      instret_q   <= '0;
      byp_valid_q <= 1'b0;
      byp_rd_q    <= '0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      instret_q   <= instret_d;
      byp_valid_q <= byp_valid_d;
      byp_rd_q    <= byp_rd_d;
      byp_data_q  <= byp_data_d;
    end
  end

  assign byp_valid = byp_valid_q;
  assign byp_rd    = byp_rd_q;
  assign byp_data  = byp_data_q;
  assign instret   = instret_q;

endmodule
